// File: rtl/dds_sine_generator_if.sv
// Control and sample bus between a DDS sine source and its consumer.
// The master drives run/tuning controls; the slave returns busy status and samples.
interface dds_sine_generator_if #(
  parameter int phase_width   = 16,
  parameter int word_size_out = 8
);
  logic                     en;
  logic                     phase_clr;
  logic                     ftw_load;
  logic [phase_width-1:0]   ftw_in;
  logic                     ftw_busy;
  logic [word_size_out-1:0] Data_out;
  logic                     sample_valid;

  modport master (
    output en, phase_clr, ftw_load, ftw_in,
    input  ftw_busy, Data_out, sample_valid
  );

  modport slave (
    input  en, phase_clr, ftw_load, ftw_in,
    output ftw_busy, Data_out, sample_valid
  );
endinterface

// File: rtl/dds_sine_generator.sv
// DDS sine source: divided sample tick, phase accumulator with phase-continuous
// FTW updates, and a two-stage quarter-wave lookup producing offset-binary samples.
module dds_sine_generator #(
  parameter int phase_width    = 16,
  parameter int lut_addr_width = 6,
  parameter int word_size_out  = 8,
  parameter int clk_div        = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  dds_sine_generator_if.slave  bus
);

  localparam int DIV_W = (clk_div > 1) ? $clog2(clk_div) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(clk_div - 1);
  localparam logic [word_size_out-1:0] MID = {1'b1, {(word_size_out-1){1'b0}}};

  // t[i] = round(127*sin(pi/2*(i+0.5)/64)); sampling at bin centres keeps the
  // four quadrants exact mirror images of each other.
  localparam logic [word_size_out-2:0] QTAB [2**lut_addr_width] = '{
      2,   5,   8,  11,  14,  17,  20,  23,  26,  29,  32,  35,  38,  41,  44,  47,
     50,  53,  56,  58,  61,  64,  67,  69,  72,  74,  77,  79,  82,  84,  86,  89,
     91,  93,  95,  97,  99, 101, 103, 105, 106, 108, 110, 111, 113, 114, 115, 117,
    118, 119, 120, 121, 122, 123, 124, 124, 125, 125, 126, 126, 127, 127, 127, 127
  };

  typedef enum logic {IDLE, RUN} state_t;

  state_t                    state, state_nxt;
  logic [DIV_W-1:0]          div_cnt;
  logic                      tick;
  logic [phase_width-1:0]    phase;
  logic [phase_width-1:0]    ftw_active;
  logic [phase_width-1:0]    ftw_pending;
  logic                      ftw_busy_r;
  logic [1:0]                quad_p1;
  logic [lut_addr_width-1:0] idx_p1;
  logic                      vld_p1;
  logic [word_size_out-1:0]  data_p2;
  logic                      vld_p2;

  function automatic logic [word_size_out-1:0] to_sample(
    input logic [1:0]                q,
    input logic [lut_addr_width-1:0] a
  );
    logic [lut_addr_width-1:0] ai;
    logic [word_size_out-1:0]  mag;
    ai  = q[0] ? ~a : a;
    mag = word_size_out'(QTAB[ai]);
    return q[1] ? (MID - mag) : (MID + mag);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.en)  state_nxt = RUN;
      RUN:  if (!bus.en) state_nxt = IDLE;
    endcase
  end

  assign tick = (state == RUN) && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (state == RUN && bus.en) begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end else begin
      div_cnt <= '0;
    end
  end

  // Accumulator and tuning words; a pending word is only promoted on a tick so
  // the phase stays continuous across frequency changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase       <= '0;
      ftw_active  <= '0;
      ftw_pending <= '0;
      ftw_busy_r  <= 1'b0;
    end else begin
      if (bus.phase_clr) phase <= '0;
      else if (tick)     phase <= phase + ftw_active;

      if (state == IDLE) begin
        if (bus.ftw_load) ftw_active <= bus.ftw_in;
      end else begin
        if (tick && ftw_busy_r) begin
          ftw_active <= ftw_pending;
          ftw_busy_r <= 1'b0;
        end
        if (bus.ftw_load && !ftw_busy_r) begin
          ftw_pending <= bus.ftw_in;
          ftw_busy_r  <= 1'b1;
        end
      end
    end
  end

  // Stage 1: quadrant and table index of the ticked phase
  always_ff @(posedge clk) begin
    if (tick) begin
      quad_p1 <= phase[phase_width-1 -: 2];
      idx_p1  <= phase[phase_width-3 -: lut_addr_width];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_p1 <= 1'b0;
    else      vld_p1 <= tick;
  end

  // Stage 2: sample register, held between ticks for the downstream filter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_p2 <= MID;
      vld_p2  <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) data_p2 <= to_sample(quad_p1, idx_p1);
    end
  end

  assign bus.Data_out     = data_p2;
  assign bus.sample_valid = vld_p2;
  assign bus.ftw_busy     = ftw_busy_r;

endmodule

// File: tb/tb_dds_sine_generator.sv
// Bench for dds_sine_generator: one instance with clk_div=1, one with clk_div=4,
// samples checked against a full-wave sine reference computed with $sin.
module tb_dds_sine_generator;
  localparam int  PW = 16;
  localparam int  OW = 8;
  localparam real PI = 3.141592653589793;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dds_sine_generator_if #(.phase_width(PW), .word_size_out(OW)) bus1 ();
  dds_sine_generator_if #(.phase_width(PW), .word_size_out(OW)) bus4 ();

  dds_sine_generator #(.phase_width(PW), .lut_addr_width(6), .word_size_out(OW), .clk_div(1))
    u_div1 (.clk(clk), .rst(rst), .bus(bus1));
  dds_sine_generator #(.phase_width(PW), .lut_addr_width(6), .word_size_out(OW), .clk_div(4))
    u_div4 (.clk(clk), .rst(rst), .bus(bus4));

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int q1[$], t1[$], q4[$], t4[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus1.sample_valid === 1'b1) begin q1.push_back(int'(bus1.Data_out)); t1.push_back(cyc); end
    if (bus4.sample_valid === 1'b1) begin q4.push_back(int'(bus4.Data_out)); t4.push_back(cyc); end
  end

  // Full-wave reference: truncate phase to 256 bins, sample sine at the bin centre.
  function automatic int ref_sample(input int p);
    int  n;
    int  mag;
    real s;
    n   = (p % 65536) / 256;
    s   = $sin(2.0 * PI * (real'(n) + 0.5) / 256.0);
    mag = $rtoi(127.0 * ((s < 0.0) ? -s : s) + 0.5);
    return (s > 0.0) ? 128 + mag : 128 - mag;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic set_in(input int sel, input logic en, input logic clr,
                        input logic ld, input logic [15:0] f);
    if (sel == 1) begin
      bus1.en = en; bus1.phase_clr = clr; bus1.ftw_load = ld; bus1.ftw_in = f;
    end else begin
      bus4.en = en; bus4.phase_clr = clr; bus4.ftw_load = ld; bus4.ftw_in = f;
    end
  endtask

  task automatic take(input int sel, output int v, output int t);
    int n = 0;
    while (((sel == 1) ? q1.size() : q4.size()) == 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (sel == 1 && q1.size() > 0) begin
      v = q1.pop_front(); t = t1.pop_front();
    end else if (sel != 1 && q4.size() > 0) begin
      v = q4.pop_front(); t = t4.pop_front();
    end else begin
      v = -1; t = -1;
      total++; bad++;
      $error("FAIL take_timeout: observed no sample expected one within 100 cycles (div %0d)", sel);
    end
  endtask

  // Load FTW in IDLE (optionally clearing phase), then enable; c0 = cycle of en.
  task automatic start(input int sel, input logic [15:0] f, input logic clr, output int c0);
    set_in(sel, 1'b0, clr, 1'b1, f);
    step(1);
    chk("idle_load_busy", (sel == 1) ? bus1.ftw_busy : bus4.ftw_busy, 0);
    set_in(sel, 1'b1, 1'b0, 1'b0, 16'd0);
    c0 = cyc;
  endtask

  task automatic stop(input int sel);
    set_in(sel, 1'b0, 1'b0, 1'b0, 16'd0);
    step(8);
    if (sel == 1) begin q1.delete(); t1.delete(); end
    else          begin q4.delete(); t4.delete(); end
  endtask

  task automatic check_seq(input int sel, input int c0, input int n, input int exp_v[8], input string tag);
    int v, t, prev;
    prev = 0;
    for (int k = 0; k < n; k++) begin
      take(sel, v, t);
      chk(tag, v, exp_v[k]);
      chk({tag, "_time"}, t, (k == 0) ? c0 + sel + 2 : prev + sel);
      prev = t;
    end
  endtask

  initial begin
    int c0, c1, v, t, f, prev;
    int quad_exp[8];
    int pend_exp[8];
    int clr_exp[8];
    int sels[2];
    quad_exp = '{130, 255, 126, 1, 130, 255, 126, 1};
    pend_exp = '{130, 255, 126, 130, 126, 130, 126, 130};
    clr_exp  = '{130, 255, 130, 255, 126, 1, 130, 255};
    sels     = '{1, 4};

    rst = 1'b1;
    set_in(1, 1'b0, 1'b0, 1'b0, 16'd0);
    set_in(4, 1'b0, 1'b0, 1'b0, 16'd0);
    #2 rst = 1'b0;
    step(3);
    chk("reset_data_div1", bus1.Data_out, 128);
    chk("reset_data_div4", bus4.Data_out, 128);
    chk("reset_valid_div1", bus1.sample_valid, 0);
    chk("reset_valid_div4", bus4.sample_valid, 0);
    chk("reset_busy_div4", bus4.ftw_busy, 0);
    rst = 1'b1;
    step(6);
    chk("idle_no_tick_div1", q1.size(), 0);
    chk("idle_no_tick_div4", q4.size(), 0);
    chk("idle_data_div4", bus4.Data_out, 128);

    // Quadrant walk at both divider settings
    start(1, 16'd16384, 1'b1, c0);
    check_seq(1, c0, 8, quad_exp, "quad_div1");
    stop(1);
    start(4, 16'd16384, 1'b1, c0);
    check_seq(4, c0, 8, quad_exp, "quad_div4");
    stop(4);

    // Pending FTW: 32768 accepted, 1 dropped while busy
    start(4, 16'd16384, 1'b1, c0);
    wait_cyc(c0 + 5); set_in(4, 1'b1, 1'b0, 1'b1, 16'd32768);
    wait_cyc(c0 + 6); chk("busy_rise", bus4.ftw_busy, 1); set_in(4, 1'b1, 1'b0, 1'b1, 16'd1);
    wait_cyc(c0 + 7); set_in(4, 1'b1, 1'b0, 1'b0, 16'd0);
    wait_cyc(c0 + 8); chk("busy_held", bus4.ftw_busy, 1);
    wait_cyc(c0 + 9); chk("busy_fall", bus4.ftw_busy, 0);
    check_seq(4, c0, 6, pend_exp, "pending");
    stop(4);

    // phase_clr coinciding with the tick at P=16384
    start(4, 16'd16384, 1'b1, c0);
    wait_cyc(c0 + 8); set_in(4, 1'b1, 1'b1, 1'b0, 16'd0);
    wait_cyc(c0 + 9); set_in(4, 1'b1, 1'b0, 1'b0, 16'd0);
    check_seq(4, c0, 8, clr_exp, "clr_tick");
    stop(4);

    // Asynchronous reset between a tick and its output, with a pending FTW
    start(4, 16'd16384, 1'b1, c0);
    wait_cyc(c0 + 7);
    take(4, v, t);
    chk("mid_first_sample", v, 130);
    wait_cyc(c0 + 8); set_in(4, 1'b1, 1'b0, 1'b1, 16'd40000);
    wait_cyc(c0 + 9);
    chk("mid_busy_before", bus4.ftw_busy, 1);
    chk("mid_data_before", bus4.Data_out, 130);
    rst = 1'b0;
    set_in(4, 1'b0, 1'b0, 1'b0, 16'd0);
    #1;
    chk("mid_async_data", bus4.Data_out, 128);
    chk("mid_async_valid", bus4.sample_valid, 0);
    chk("mid_async_busy", bus4.ftw_busy, 0);
    wait_cyc(c0 + 12);
    rst = 1'b1;
    wait_cyc(c0 + 16);
    chk("mid_no_pulse", q4.size(), 0);
    chk("mid_data_after", bus4.Data_out, 128);
    start(4, 16'd16384, 1'b0, c1);
    take(4, v, t);
    chk("mid_phase_zero", v, 130);
    chk("mid_phase_zero_time", t, c1 + 6);
    take(4, v, t);
    chk("mid_second", v, 255);
    stop(4);

    // Randomized tuning words against the sine reference
    for (int r = 0; r < 3; r++) begin
      foreach (sels[i]) begin
        f = int'($urandom_range(1, 65535));
        start(sels[i], 16'(f), 1'b1, c0);
        prev = 0;
        for (int k = 0; k < 10; k++) begin
          take(sels[i], v, t);
          chk("rand_sample", v, ref_sample(k * f));
          chk("rand_time", t, (k == 0) ? c0 + sels[i] + 2 : prev + sels[i]);
          prev = t;
        end
        stop(sels[i]);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dds_sine_generator.md
# dds_sine_generator

Direct digital synthesis source that produces an unsigned 8-bit sine sample stream for the FIR low-pass filter stage, whose `Data_in` it drives directly. A phase accumulator advances by a frequency tuning word (FTW) once per sample tick. Ticks come from an internal clock divider. The phase is mapped through a quarter-wave sine table to an offset-binary sample centred on 128. FTW updates are phase-continuous and take effect only on a sample boundary, using a one-deep pending register with a busy flag.

## Interface
- `phase_width`, 16: accumulator width in bits.
- `lut_addr_width`, 6: quarter-wave table address bits (64 entries).
- `word_size_out`, 8: sample width; must match the FIR `word_size_in`.
- `clk_div`, 4: clock cycles per sample tick; must be ≥1.
- `clk` input 1: sole clock; all logic is on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `en` input 1: run enable.
- `phase_clr` input 1: synchronous clear of the phase accumulator.
- `ftw_in` input `phase_width`: new tuning word.
- `ftw_load` input 1: one-cycle strobe that captures `ftw_in`.
- `ftw_busy` output 1: a loaded FTW is pending and not yet applied.
- `Data_out` output `word_size_out`: unsigned sample to the FIR `Data_in`.
- `sample_valid` output 1: one-cycle pulse when `Data_out` updates.

## Operation
- **Reset values** (while `rst`=0):
  - `phase`=0, `ftw_active`=0, `ftw_pending`=0.
  - `ftw_busy`=0, divider=0, state IDLE.
  - Pipeline valid bits cleared.
  - `Data_out`=128, `sample_valid`=0.
- **FSM, state IDLE:**
  - Divider held at 0; `phase` held; `Data_out` holds its last value.
  - `ftw_load` writes `ftw_active` directly; `ftw_busy` stays 0.
  - `en`=1 moves to RUN next cycle.
- **FSM, state RUN:**
  - Divider counts 0..`clk_div`-1 and wraps.
  - A tick occurs in the cycle where divider = `clk_div`-1, or every cycle when `clk_div`=1.
  - `en`=0 moves to IDLE next cycle and resets the divider to 0.
  - A sample already in the pipeline is still emitted.
- **Tick with current phase P:**
  - `phase` ← (P + `ftw_active`) mod 2^`phase_width`.
  - P is sent into the lookup pipeline.
  - If `ftw_busy`=1, then `ftw_active` ← `ftw_pending` and `ftw_busy` ← 0. The new FTW therefore affects the increment at the following tick.
- **FTW loading in RUN:**
  - `ftw_load` with `ftw_busy`=0 captures `ftw_in` into `ftw_pending` and sets `ftw_busy`=1 next cycle.
  - `ftw_load` with `ftw_busy`=1 is ignored and the new word is dropped.
  - `ftw_load` in the same cycle as a tick with `ftw_busy`=0 is captured as pending and applied at the next tick.
- **`phase_clr`:**
  - Forces `phase` ← 0 next cycle and takes priority over the tick increment.
  - A tick in that same cycle still emits the sample for the pre-clear phase P.
  - Honoured in both IDLE and RUN.
- **Lookup:**
  - Quadrant `q` = P[msb:msb-1]; index `a` = the next `lut_addr_width` bits.
  - Table entry: t[i] = round(127·sin(π/2·(i+0.5)/2^`lut_addr_width`)), so t[0]=2 and t[63]=127.
  - `q`=0: 128+t[a].
  - `q`=1: 128+t[~a].
  - `q`=2: 128−t[a].
  - `q`=3: 128−t[~a].
  - Output range is 1..255. No wrap or overflow is possible.
  - Lower phase bits are truncated, not rounded.
- **Reset mid-operation:** all state returns to reset values immediately. In-flight samples and a pending FTW are discarded.

## Timing
- Tick in cycle T: stage-1 register (quadrant and index) captured at the end of T.
- `Data_out` is registered at the end of T+1. `Data_out` and `sample_valid` are high in cycle T+2. Latency is 2 cycles.
- `sample_valid` is high for exactly 1 cycle per tick. `Data_out` holds between ticks, because the FIR samples every clock.
- Throughput is one sample per `clk_div` cycles. Back-to-back samples are supported at `clk_div`=1.
- First tick after IDLE→RUN occurs in the `clk_div`-th RUN cycle.
- `ftw_busy` rises 1 cycle after an accepted load and falls 1 cycle after the applying tick.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles, then release → `Data_out`=128, `sample_valid`=0, `ftw_busy`=0, no tick while `en`=0.
- **Quadrant walk:** `clk_div`=1, load FTW 16384 in IDLE, assert `en` → successive samples 130, 255, 126, 1, repeating; first `sample_valid` 2 cycles after the first tick.
- **Divider:** `clk_div`=4, FTW 16384 → `sample_valid` exactly every 4 cycles, same sequence 130, 255, 126, 1.
- **Pending FTW:** in RUN with FTW 16384, load 32768, then load 1 while busy → 1 is dropped; increment switches to 32768 one tick after the applying tick; `ftw_busy` clears as specified.
- **phase_clr with tick:** assert `phase_clr` in a tick cycle with P=16384 → emitted sample 255, next phase 0, next sample 130.
- **Async reset mid-stream:** drop `rst` between a tick and its output → `Data_out`=128 immediately, no `sample_valid` pulse, `phase`=0 after release.
